// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the MIPS hazard controller: opcode/funct codes,
// forwarding-select encodings and the "source not used" Tuse value.
package hazard_ctrl_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUBU    = 6'h23;

    // Forwarding-mux selects
    localparam logic [1:0] FWD_RF = 2'd0;  // register file, no forward
    localparam logic [1:0] FWD_E  = 2'd1;  // jal link value held in E
    localparam logic [1:0] FWD_M  = 2'd2;  // ALU result in M
    localparam logic [1:0] FWD_W  = 2'd3;  // write-back value

    typedef logic [1:0] tick_t;            // Tnew / Tuse in cycles

    localparam tick_t TUSE_NONE = 2'd3;

endpackage

// File: rtl/hazard_decode.sv
// Combinational decode of the D-stage instruction into destination, Tnew
// and per-source Tuse. Zero latency; no flow control.
module hazard_decode
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [31:0]      instr_d,
    output logic [REG_W-1:0] rs,
    output logic [REG_W-1:0] rt,
    output logic [REG_W-1:0] dst,
    output tick_t            tnew,
    output tick_t            tuse_rs,
    output tick_t            tuse_rt
);

    logic [5:0]       op;
    logic [5:0]       fn;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] dst_raw;
    tick_t            tnew_raw;
    logic             unused_shamt;

    assign op           = instr_d[31:26];
    assign fn           = instr_d[5:0];
    assign rs           = instr_d[21 +: REG_W];
    assign rt           = instr_d[16 +: REG_W];
    assign rd           = instr_d[11 +: REG_W];
    assign unused_shamt = ^instr_d[10:6];

    always_comb begin
        dst_raw  = '0;
        tnew_raw = 2'd0;
        tuse_rs  = TUSE_NONE;
        tuse_rt  = TUSE_NONE;
        case (op)
            OP_SPECIAL: begin
                case (fn)
                    FN_ADDU, FN_SUBU: begin
                        dst_raw  = rd;
                        tnew_raw = 2'd1;
                        tuse_rs  = 2'd1;
                        tuse_rt  = 2'd1;
                    end
                    FN_JR:   tuse_rs = 2'd0;
                    default: ;
                endcase
            end
            OP_ORI: begin
                dst_raw  = rt;
                tnew_raw = 2'd1;
                tuse_rs  = 2'd1;
            end
            OP_LUI: begin
                dst_raw  = rt;
                tnew_raw = 2'd1;
            end
            OP_LW: begin
                dst_raw  = rt;
                tnew_raw = 2'd2;
                tuse_rs  = 2'd1;
            end
            OP_SW: begin
                tuse_rs = 2'd1;
                tuse_rt = 2'd2;
            end
            OP_BEQ: begin
                tuse_rs = 2'd0;
                tuse_rt = 2'd0;
            end
            OP_JAL: begin
                dst_raw  = '1;
                tnew_raw = 2'd0;
            end
            default: ;
        endcase
    end

    // $0 is never a real producer, so it carries no Tnew either
    assign dst  = dst_raw;
    assign tnew = (dst_raw == '0) ? 2'd0 : tnew_raw;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/forwarding controller for a 5-stage MIPS pipeline with its own E/M/W
// scoreboard. Selects and stall are combinational; only PC and IF/ID freeze.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int FW_W  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr_d,
    output logic            stall,
    output logic            en_pc,
    output logic            en_d,
    output logic            clr_e,
    output logic [FW_W-1:0] fwd_rs_d,
    output logic [FW_W-1:0] fwd_rt_d,
    output logic [FW_W-1:0] fwd_rs_e,
    output logic [FW_W-1:0] fwd_rt_e,
    output logic [FW_W-1:0] fwd_rt_m
);

    logic [REG_W-1:0] d_rs, d_rt, d_dst;
    tick_t            d_tnew, d_tuse_rs, d_tuse_rt;

    logic [REG_W-1:0] e_rs, e_rt, e_dst;
    tick_t            e_tnew;
    logic [REG_W-1:0] m_rt, m_dst;
    tick_t            m_tnew;
    logic [REG_W-1:0] w_dst;

    logic stall_rs, stall_rt;

    hazard_decode #(.REG_W(REG_W)) u_decode (
        .instr_d (instr_d),
        .rs      (d_rs),
        .rt      (d_rt),
        .dst     (d_dst),
        .tnew    (d_tnew),
        .tuse_rs (d_tuse_rs),
        .tuse_rt (d_tuse_rt)
    );

    // Scoreboard keeps moving during a stall; the stalled slot enters E as a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            e_rs   <= '0;
            e_rt   <= '0;
            e_dst  <= '0;
            e_tnew <= 2'd0;
            m_rt   <= '0;
            m_dst  <= '0;
            m_tnew <= 2'd0;
            w_dst  <= '0;
        end else begin
            if (stall) begin
                e_rs   <= '0;
                e_rt   <= '0;
                e_dst  <= '0;
                e_tnew <= 2'd0;
            end else begin
                e_rs   <= d_rs;
                e_rt   <= d_rt;
                e_dst  <= d_dst;
                e_tnew <= d_tnew;
            end
            m_rt   <= e_rt;
            m_dst  <= e_dst;
            m_tnew <= (e_tnew == 2'd0) ? 2'd0 : e_tnew - 2'd1;
            w_dst  <= m_dst;
        end
    end

    function automatic logic needs_wait(input logic [REG_W-1:0] r, input tick_t tuse,
                                        input logic [REG_W-1:0] ed, input tick_t et,
                                        input logic [REG_W-1:0] md, input tick_t mt);
        return (r != '0) && (((r == ed) && (et > tuse)) || ((r == md) && (mt > tuse)));
    endfunction

    assign stall_rs = needs_wait(d_rs, d_tuse_rs, e_dst, e_tnew, m_dst, m_tnew);
    assign stall_rt = needs_wait(d_rt, d_tuse_rt, e_dst, e_tnew, m_dst, m_tnew);
    assign stall    = stall_rs | stall_rt;
    assign en_pc    = ~stall;
    assign en_d     = ~stall;
    assign clr_e    = stall;

    // Youngest ready producer wins; E can only supply a jal link (Tnew 0)
    function automatic logic [FW_W-1:0] sel_d(input logic [REG_W-1:0] r,
                                              input logic [REG_W-1:0] ed, input tick_t et,
                                              input logic [REG_W-1:0] md, input tick_t mt,
                                              input logic [REG_W-1:0] wd);
        if (r == '0)                       return FW_W'(FWD_RF);
        if ((r == ed) && (et == 2'd0))     return FW_W'(FWD_E);
        if ((r == md) && (mt == 2'd0))     return FW_W'(FWD_M);
        if (r == wd)                       return FW_W'(FWD_W);
        return FW_W'(FWD_RF);
    endfunction

    function automatic logic [FW_W-1:0] sel_e(input logic [REG_W-1:0] r,
                                              input logic [REG_W-1:0] md, input tick_t mt,
                                              input logic [REG_W-1:0] wd);
        if (r == '0)                       return FW_W'(FWD_RF);
        if ((r == md) && (mt == 2'd0))     return FW_W'(FWD_M);
        if (r == wd)                       return FW_W'(FWD_W);
        return FW_W'(FWD_RF);
    endfunction

    assign fwd_rs_d = sel_d(d_rs, e_dst, e_tnew, m_dst, m_tnew, w_dst);
    assign fwd_rt_d = sel_d(d_rt, e_dst, e_tnew, m_dst, m_tnew, w_dst);
    assign fwd_rs_e = sel_e(e_rs, m_dst, m_tnew, w_dst);
    assign fwd_rt_e = sel_e(e_rt, m_dst, m_tnew, w_dst);
    assign fwd_rt_m = ((m_rt != '0) && (m_rt == w_dst)) ? FW_W'(FWD_W) : FW_W'(FWD_RF);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven check of hazard_ctrl: one row per clock cycle with
// hand-computed stall and forwarding selects, plus reset/2-stall sequences.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [31:0] instr_d;
    logic       stall, en_pc, en_d, clr_e;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;

    int n_vec = 0;
    int n_err = 0;

    hazard_ctrl #(.REG_W(5), .FW_W(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .instr_d  (instr_d),
        .stall    (stall),
        .en_pc    (en_pc),
        .en_d     (en_d),
        .clr_e    (clr_e),
        .fwd_rs_d (fwd_rs_d),
        .fwd_rt_d (fwd_rt_d),
        .fwd_rs_e (fwd_rs_e),
        .fwd_rt_e (fwd_rt_e),
        .fwd_rt_m (fwd_rt_m)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic        stl;
        logic [1:0]  frs_d, frt_d, frs_e, frt_e, frt_m;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    task automatic add(input logic r, input logic [31:0] ins, input logic s,
                       input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                       input logic [1:0] d, input logic [1:0] e);
        vec_t v;
        v.rst = r; v.instr = ins; v.stl = s;
        v.frs_d = a; v.frt_d = b; v.frs_e = c; v.frt_e = d; v.frt_m = e;
        vecs.push_back(v);
    endtask

    // Drive one cycle's inputs after the falling edge and compare before the rising edge
    task automatic apply(input string name, input vec_t v);
        logic [13:0] act, exp;
        @(negedge clk);
        reset   = v.rst;
        instr_d = v.instr;
        #1;
        act = {stall, en_pc, en_d, clr_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m};
        exp = {v.stl, ~v.stl, ~v.stl, v.stl, v.frs_d, v.frt_d, v.frs_e, v.frt_e, v.frt_m};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got {stall,en_pc,en_d,clr_e,rs_d,rt_d,rs_e,rt_e,rt_m}=%b required %b",
                     name, act, exp);
        end
    endtask

    logic [31:0] NOP, LW8, ADDU9, BEQ8, ORI5, BEQ55, JAL, JR31, ADDU0, ADDU3, LW6, SW6, LW31;

    initial begin
        vec_t h;
        NOP   = 32'h0;
        LW8   = enc_i(6'h23, 5'd0, 5'd8, 16'd0);
        ADDU9 = enc_r(5'd8, 5'd8, 5'd9, 6'h21);
        BEQ8  = enc_i(6'h04, 5'd8, 5'd0, 16'd3);
        ORI5  = enc_i(6'h0d, 5'd0, 5'd5, 16'd1);
        BEQ55 = enc_i(6'h04, 5'd5, 5'd5, 16'd0);
        JAL   = enc_j(6'h03, 26'h100);
        JR31  = enc_r(5'd31, 5'd0, 5'd0, 6'h08);
        ADDU0 = enc_r(5'd1, 5'd2, 5'd0, 6'h21);
        ADDU3 = enc_r(5'd0, 5'd0, 5'd3, 6'h21);
        LW6   = enc_i(6'h23, 5'd0, 5'd6, 16'd0);
        SW6   = enc_i(6'h2b, 5'd0, 5'd6, 16'd0);
        LW31  = enc_i(6'h23, 5'd0, 5'd31, 16'd0);

        //   rst   instr  stall rs_d  rt_d  rs_e  rt_e  rt_m
        add(1'b1, NOP,   1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);  // reset state
        add(1'b0, LW8,   1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        add(1'b0, ADDU9, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);  // lw-use: 1 stall
        add(1'b0, ADDU9, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        add(1'b0, NOP,   1'b0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd0);  // addu in E takes W
        add(1'b0, LW8,   1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        add(1'b0, BEQ8,  1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);  // lw-beq: 2 stalls
        add(1'b0, BEQ8,  1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        add(1'b0, BEQ8,  1'b0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0);
        add(1'b0, ORI5,  1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        add(1'b0, BEQ55, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);  // alu-beq: 1 stall
        add(1'b0, BEQ55, 1'b0, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0);
        add(1'b0, JAL,   1'b0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd0);
        add(1'b0, JR31,  1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0);  // jal link from E
        add(1'b0, ADDU0, 1'b0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0);
        add(1'b0, ADDU3, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);  // $0 never forwards
        add(1'b0, LW6,   1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        add(1'b0, SW6,   1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);  // lw-sw: no stall
        add(1'b0, NOP,   1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        add(1'b0, NOP,   1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3);  // store data via W

        reset   = 1'b1;
        instr_d = 32'h0;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

        // lw $31 then jr $31: two stall cycles, then write-back forward
        h = '{1'b0, LW31, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}; apply("lw_jr_0", h);
        h = '{1'b0, JR31, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}; apply("lw_jr_1", h);
        h = '{1'b0, JR31, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}; apply("lw_jr_2", h);
        h = '{1'b0, JR31, 1'b0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0}; apply("lw_jr_3", h);

        // Reset lands mid-stall: stall holds this cycle, is gone the next
        h = '{1'b0, LW8,  1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}; apply("rst_0", h);
        h = '{1'b0, BEQ8, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}; apply("rst_1", h);
        h = '{1'b1, BEQ8, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}; apply("rst_2", h);
        h = '{1'b0, BEQ8, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}; apply("rst_3", h);
        h = '{1'b0, NOP,  1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}; apply("rst_4", h);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
